// File: rtl/sort_frame_sequencer.sv
// sort_frame_sequencer: runs one load/drain cycle of a sorter instance per
// video frame. Generates pseudo-random keys, sequences the sorter's reset,
// enable and push/pop phase, and checks the drained stream for ordering and
// checksum. Error flags are sticky; oPass counts completed runs.
module sort_frame_sequencer #(
  parameter int unsigned HBIT = 15,
  parameter int unsigned R_SZ = 64,
  parameter logic [31:0] SEED = 32'h12345678
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  input  logic          iEndFrame,
  input  logic          iStep,
  input  logic          iHold,
  input  logic          iAscending,
  input  logic          iErrClr,
  input  logic [HBIT:0] iSortData,
  output logic          oSortRst,
  output logic          oSortEn,
  output logic          oSortIn,
  output logic [HBIT:0] oSortData,
  output logic          oBusy,
  output logic [15:0]   oPass,
  output logic          oErrUnsorted,
  output logic          oErrChecksum,
  output logic          oOverrun
);

  localparam int unsigned CW = (R_SZ > 1) ? $clog2(R_SZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(R_SZ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_CHECK
  } state_t;

  state_t        state;
  logic          ef_q;
  logic [31:0]   gen;
  logic [31:0]   saved_seed;
  logic [31:0]   gen_next;
  logic [CW-1:0] count;
  logic [31:0]   sum;
  logic          first_pop;
  logic          asc_q;
  logic [HBIT:0] last;
  logic [HBIT:0] key;
  logic [HBIT:0] v;
  logic          start;
  logic          order_bad;
  logic          set_uns;
  logic          set_ck;
  logic          set_ovr;

  // Next generator value, drained value in key space, and error set conditions
  always_comb begin
    key       = gen[HBIT:0];
    gen_next  = (gen * 32'd11) + (gen >> 16);
    v         = asc_q ? ~iSortData : iSortData;
    start     = iEndFrame & ~ef_q;
    order_bad = asc_q ? (last > v) : (last < v);
    set_uns   = (state == S_DRAIN) && iStep && !first_pop && order_bad;
    set_ck    = (state == S_CHECK) && (sum != '0);
    set_ovr   = start && (state != S_IDLE);
  end

  // Run sequencer: frame edge starts CLEAR -> LOAD -> DRAIN -> CHECK; all
  // sorter commands are registered so the sorter acts one cycle after iStep
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= S_IDLE;
      ef_q         <= 1'b0;
      gen          <= SEED;
      saved_seed   <= SEED;
      count        <= '0;
      sum          <= '0;
      first_pop    <= 1'b0;
      asc_q        <= 1'b0;
      last         <= '0;
      oSortRst     <= 1'b0;
      oSortEn      <= 1'b0;
      oSortIn      <= 1'b0;
      oSortData    <= '0;
      oBusy        <= 1'b0;
      oPass        <= '0;
      oErrUnsorted <= 1'b0;
      oErrChecksum <= 1'b0;
      oOverrun     <= 1'b0;
    end else begin
      ef_q         <= iEndFrame;
      oErrUnsorted <= set_uns | (oErrUnsorted & ~iErrClr);
      oErrChecksum <= set_ck  | (oErrChecksum & ~iErrClr);
      oOverrun     <= set_ovr | (oOverrun & ~iErrClr);
      oSortRst     <= 1'b0;
      oSortEn      <= 1'b0;
      oSortIn      <= 1'b0;
      oSortData    <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLEAR;
            oBusy    <= 1'b1;
            oSortRst <= 1'b1;
          end
        end
        S_CLEAR: begin
          count     <= '0;
          sum       <= '0;
          first_pop <= 1'b1;
          asc_q     <= iAscending;
          if (iHold) gen <= saved_seed;
          else       saved_seed <= gen;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          if (iStep) begin
            oSortEn   <= 1'b1;
            oSortIn   <= 1'b1;
            oSortData <= asc_q ? ~key : key;
            sum       <= sum + 32'(key);
            gen       <= gen_next;
            if (count == LAST) begin
              count <= '0;
              state <= S_DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (iStep) begin
            oSortEn   <= 1'b1;
            sum       <= sum - 32'(v);
            last      <= v;
            first_pop <= 1'b0;
            if (count == LAST) begin
              count <= '0;
              state <= S_CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_CHECK: begin
          oPass <= oPass + 16'd1;
          oBusy <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Bench for sort_frame_sequencer: a max-first sorter model drives iSortData,
// a run-level model predicts keys, pass count and error flags.
module tb_sort_frame_sequencer;

  localparam int unsigned HBIT = 15;
  localparam int unsigned R_SZ = 4;
  localparam logic [31:0] SEED = 32'h12345678;
  localparam int NK = 4;

  logic        clk = 1'b0;
  logic        iRST_n;
  logic        iEndFrame;
  logic        iStep = 1'b0;
  logic        iHold;
  logic        iAscending;
  logic        iErrClr;
  logic [15:0] iSortData = '0;
  logic        oSortRst, oSortEn, oSortIn, oBusy;
  logic [15:0] oSortData, oPass;
  logic        oErrUnsorted, oErrChecksum, oOverrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_frame_sequencer #(.HBIT(HBIT), .R_SZ(R_SZ), .SEED(SEED)) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .iEndFrame(iEndFrame), .iStep(iStep),
    .iHold(iHold), .iAscending(iAscending), .iErrClr(iErrClr),
    .iSortData(iSortData), .oSortRst(oSortRst), .oSortEn(oSortEn),
    .oSortIn(oSortIn), .oSortData(oSortData), .oBusy(oBusy), .oPass(oPass),
    .oErrUnsorted(oErrUnsorted), .oErrChecksum(oErrChecksum),
    .oOverrun(oOverrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // step strobe generator: high one cycle in every step_div
  int step_div = 0;
  int stepc = 0;
  always @(posedge clk) begin
    #1;
    iStep = (step_div != 0) && ((stepc % step_div) == 0);
    stepc++;
  end

  logic step_prev = 1'b0;
  always @(posedge clk) step_prev <= iStep;

  // sorter model: largest stored value at the head; fault 1 swaps the first
  // two pops, fault 2 returns 0 on the last pop
  logic [15:0] sq[$];
  logic [15:0] head = '0;
  logic [15:0] drained[NK];
  int          pops = 0;
  int          fault_mode = 0;

  function automatic logic [15:0] present();
    int imax;
    int i2;
    imax = -1;
    i2 = -1;
    if (sq.size() == 0) return '0;
    if (fault_mode == 2 && pops == NK - 1) return '0;
    for (int i = 0; i < sq.size(); i++)
      if (imax < 0 || sq[i] > sq[imax]) imax = i;
    if (fault_mode == 1 && pops == 0) begin
      for (int i = 0; i < sq.size(); i++)
        if (i != imax && (i2 < 0 || sq[i] > sq[i2])) i2 = i;
      if (i2 >= 0) return sq[i2];
    end
    return sq[imax];
  endfunction

  always @(negedge clk) begin
    int idx;
    if (!iRST_n || oSortRst) begin
      sq.delete();
      pops = 0;
    end else if (oSortEn && oSortIn) begin
      sq.push_back(oSortData);
    end else if (oSortEn) begin
      if (pops < NK) drained[pops] = head;
      pops++;
      idx = -1;
      for (int i = 0; i < sq.size(); i++)
        if (idx < 0 && sq[i] == head) idx = i;
      if (idx >= 0) sq.delete(idx);
      else if (sq.size() > 0) sq.delete(0);
    end
    head = present();
    iSortData = head;
  end

  // run-level model state
  logic [31:0] gen_m = SEED;
  logic [31:0] saved_m = SEED;
  logic [15:0] exp_key[NK];
  logic [15:0] exp_push[NK];
  logic [15:0] captured[NK];
  int          exp_pass = 0;
  bit          exp_uns = 0, exp_ck = 0, exp_ovr = 0;
  bit          run_asc = 0;
  int          pushes = 0;

  // per-cycle compare of sorter commands
  always @(negedge clk) begin
    if (iRST_n) begin
      if (oSortEn && oSortIn) begin
        if (pushes < NK) begin
          captured[pushes] = oSortData;
          chk("push_key", {16'h0, oSortData}, {16'h0, exp_push[pushes]});
        end else begin
          chk("push_excess", pushes, NK - 1);
        end
        pushes++;
      end
      if (oSortEn) chk("en_without_step", {31'h0, step_prev}, 1);
      if (!oBusy) chk("idle_cmds", {13'h0, oSortRst, oSortEn, oSortIn, oSortData}, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input bit h, input bit a, input int mode, input int div);
    int n;
    iHold = h;
    iAscending = a;
    fault_mode = mode;
    step_div = div;
    run_asc = a;
    pushes = 0;
    if (h) gen_m = saved_m;
    else   saved_m = gen_m;
    for (int i = 0; i < NK; i++) begin
      exp_key[i]  = gen_m[15:0];
      exp_push[i] = a ? ~gen_m[15:0] : gen_m[15:0];
      gen_m = (gen_m * 32'd11) + (gen_m >> 16);
    end
    @(posedge clk); #1 iEndFrame = 1'b1;
    n = 0;
    while (!oBusy && n < 20) begin @(negedge clk); n++; end
    chk("busy_after_start", {31'h0, oBusy}, 1);
    @(posedge clk); #1 iEndFrame = 1'b0;
  endtask

  task automatic finish_run();
    int n;
    logic [31:0] s;
    logic [15:0] v, vp;
    bit uns;
    n = 0;
    while (oBusy && n < 500) begin @(negedge clk); n++; end
    chk("run_completes", {31'h0, oBusy}, 0);
    exp_pass++;
    s = '0;
    uns = 0;
    vp = '0;
    for (int j = 0; j < NK; j++) begin
      v = run_asc ? ~drained[j] : drained[j];
      s = s + {16'h0, exp_key[j]} - {16'h0, v};
      if (j > 0 && (run_asc ? (vp > v) : (vp < v))) uns = 1;
      vp = v;
    end
    if (uns) exp_uns = 1;
    if (s != 0) exp_ck = 1;
    chk("pass_count", {16'h0, oPass}, exp_pass & 32'hFFFF);
    chk("push_total", pushes, NK);
    chk("pop_total", pops, NK);
    chk("err_unsorted", {31'h0, oErrUnsorted}, {31'h0, exp_uns});
    chk("err_checksum", {31'h0, oErrChecksum}, {31'h0, exp_ck});
    chk("overrun", {31'h0, oOverrun}, {31'h0, exp_ovr});
  endtask

  task automatic do_run(input bit h, input bit a, input int mode, input int div, input bit ovr);
    int n;
    start_run(h, a, mode, div);
    if (ovr) begin
      n = 0;
      while (pops < 1 && n < 200) begin @(negedge clk); n++; end
      chk("reached_drain", {31'h0, (pops >= 1)}, 1);
      @(posedge clk); #1 iEndFrame = 1'b1;
      repeat (2) @(posedge clk);
      #1 iEndFrame = 1'b0;
      exp_ovr = 1;
    end
    finish_run();
  endtask

  task automatic clear_errs();
    @(posedge clk); #1 iErrClr = 1'b1;
    @(posedge clk); #1 iErrClr = 1'b0;
    exp_uns = 0;
    exp_ck = 0;
    exp_ovr = 0;
    @(negedge clk);
    chk("clr_flags", {29'h0, oErrUnsorted, oErrChecksum, oOverrun}, 0);
  endtask

  initial begin
    int n;
    iRST_n = 1'b0;
    iEndFrame = 1'b0;
    iHold = 1'b0;
    iAscending = 1'b0;
    iErrClr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {25'h0, oSortRst, oSortEn, oSortIn, oBusy, oErrUnsorted, oErrChecksum, oOverrun}, 0);
    chk("reset_data", {16'h0, oSortData}, 0);
    chk("reset_pass", {16'h0, oPass}, 0);
    @(posedge clk); #1 iRST_n = 1'b1;

    do_run(0, 0, 0, 1, 0);
    chk("run1_key0", {16'h0, captured[0]}, 32'h5678);
    chk("run1_key1", {16'h0, captured[1]}, 32'hC95C);
    chk("run1_pass", {16'h0, oPass}, 1);

    do_run(1, 0, 0, 1, 0);
    chk("hold_key0", {16'h0, captured[0]}, 32'h5678);

    do_run(1, 1, 0, 1, 0);
    chk("asc_key0", {16'h0, captured[0]}, 32'hA987);

    do_run(0, 0, 0, 1, 0);

    do_run(0, 0, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("uns_persist", {31'h0, oErrUnsorted}, {31'h0, exp_uns});
    clear_errs();

    do_run(0, 1, 1, 2, 0);
    clear_errs();

    do_run(0, 0, 2, 1, 0);
    clear_errs();

    do_run(0, 0, 0, 3, 1);
    chk("overrun_set", {31'h0, oOverrun}, 1);
    clear_errs();

    // abort mid-load with an asynchronous reset
    start_run(0, 0, 0, 3);
    n = 0;
    while (pushes < 2 && n < 100) begin @(negedge clk); n++; end
    chk("reached_load", {31'h0, (pushes >= 2)}, 1);
    @(posedge clk); #1 iRST_n = 1'b0;
    @(negedge clk);
    chk("midreset_ctrl", {25'h0, oSortRst, oSortEn, oSortIn, oBusy, oErrUnsorted, oErrChecksum, oOverrun}, 0);
    chk("midreset_data", {16'h0, oSortData}, 0);
    chk("midreset_pass", {16'h0, oPass}, 0);
    gen_m = SEED;
    saved_m = SEED;
    exp_pass = 0;
    exp_uns = 0;
    exp_ck = 0;
    exp_ovr = 0;
    @(posedge clk); #1 iRST_n = 1'b1;

    do_run(0, 0, 0, 1, 0);
    chk("post_reset_key0", {16'h0, captured[0]}, 32'h5678);
    chk("post_reset_pass", {16'h0, oPass}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
